// File: rtl/gpr_scoreboard.sv
// Integer register file with per-register pending-write counters.
// Ports: rs1/rs2 read (bypassed), busy flags, issue handshake, writeback, wb_err.
module gpr_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_err
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [1:0]      pend_q [NREG];
    logic [1:0]      pend_d [NREG];
    logic            wb_err_q;
    logic            wb_err_d;

    logic issue_acc;
    logic wb_act;

    // Ready looks only at registered counts: no credit for a retiring write.
    assign issue_ready = (issue_rd == '0) || (pend_q[issue_rd] != 2'd3);
    assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_act      = wb_valid && (wb_rd != '0);
    assign wb_err      = wb_err_q;

    always_comb begin
        rs1_out  = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            if (wb_valid && (wb_rd == rs1_addr)) begin
                rs1_out = wb_data;
            end else begin
                rs1_out = regs_q[rs1_addr];
            end
            // The last outstanding write retiring now clears busy early.
            rs1_busy = (pend_q[rs1_addr] != 2'd0) &&
                       !(wb_valid && (wb_rd == rs1_addr) &&
                         (pend_q[rs1_addr] == 2'd1));
        end
    end

    always_comb begin
        rs2_out  = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            if (wb_valid && (wb_rd == rs2_addr)) begin
                rs2_out = wb_data;
            end else begin
                rs2_out = regs_q[rs2_addr];
            end
            rs2_busy = (pend_q[rs2_addr] != 2'd0) &&
                       !(wb_valid && (wb_rd == rs2_addr) &&
                         (pend_q[rs2_addr] == 2'd1));
        end
    end

    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        wb_err_d = wb_err_q;
        if (wb_act && (pend_q[wb_rd] == 2'd0)) begin
            wb_err_d = 1'b1;
        end
        // x0 is skipped entirely: its value and count never change.
        for (int r = 1; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = issue_acc && (issue_rd == AW'(r));
            dec = wb_act && (wb_rd == AW'(r)) && (pend_q[r] != 2'd0);
            if (wb_act && (wb_rd == AW'(r))) begin
                regs_d[r] = wb_data;
            end
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + 2'd1;
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= 2'd0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
                pend_q[i] <= pend_d[i];
            end
            wb_err_q <= wb_err_d;
        end
    end

endmodule

// File: doc/gpr_scoreboard.md
# gpr_scoreboard

Integer register file for the 64-bit core, with a per-register pending-write scoreboard. It is the producer of the `rs1`/`rs2` operand values that decode passes to the ALU operand-select muxes. It accepts writeback results, bypasses a same-cycle writeback to the read ports, and reports whether a source register still has writes in flight so decode can stall. Decode (issue side) and writeback (retire side) both sit on it.

## Interface
Parameters:
- `XLEN`, 64: register data width.
- `NREG`, 32: number of architectural registers. The address width is log2(NREG), 5 bits by default.

Ports:
- `clk` in, 1: the single clock. All state updates on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `rs1_addr` in, 5: source register 1 index.
- `rs2_addr` in, 5: source register 2 index.
- `rs1_out` out, XLEN: source 1 value (combinational).
- `rs2_out` out, XLEN: source 2 value (combinational).
- `rs1_busy` out, 1: source 1 still has unretired writes.
- `rs2_busy` out, 1: source 2 still has unretired writes.
- `issue_valid` in, 1: decode is dispatching an instruction that will write `issue_rd`.
- `issue_rd` in, 5: destination of the dispatched instruction.
- `issue_ready` out, 1: the scoreboard can accept the issue this cycle.
- `wb_valid` in, 1: writeback result present.
- `wb_rd` in, 5: writeback destination.
- `wb_data` in, XLEN: writeback value.
- `wb_err` out, 1: sticky flag, set when a writeback arrives with no pending issue.

## Operation
State:
- `regs[NREG]`, XLEN bits each.
- `pend[NREG]`, a 2-bit saturating counter per register holding the number of in-flight writes.
- `wb_err`.

Register x0:
- Always reads 0.
- Writes to it are discarded.
- `pend[0]` is never modified and stays 0.
- An issue or writeback with rd=0 has no effect on any state.

Read path, evaluated independently for rs1 and rs2 (combinational):
- If addr==0, output 0.
- Else if `wb_valid` and `wb_rd`==addr, output `wb_data` (write-through bypass).
- Else output `regs[addr]`.

Busy, for addr≠0:
- Busy = `pend[addr]`≠0, except it is 0 when `wb_valid` && `wb_rd`==addr && `pend[addr]`==1, because the last write is retiring this cycle.
- For addr==0, busy = 0.

Issue handshake:
- `issue_ready` = (`issue_rd`==0) || (`pend[issue_rd]`≠3).
- There is no bypass credit for a same-cycle writeback. Ready depends only on registered state and `issue_rd`.
- An issue is accepted when `issue_valid` && `issue_ready`.
- If the issue is not accepted, no state changes. Decode must hold `issue_valid` and `issue_rd` stable until accepted.
- `issue_ready` is defined regardless of `issue_valid`.

Writeback, on each clock edge with `wb_valid` && `wb_rd`≠0:
- `regs[wb_rd]` <= `wb_data`.
- If `pend[wb_rd]`>0, decrement it.
- If `pend[wb_rd]`==0, the counter stays 0 (no underflow) and `wb_err` <= 1.

Counter update for register r on each edge:
- +1 if an issue to r is accepted.
- −1 if a writeback to r occurs with `pend[r]`>0.
- If both happen, the net change is 0.
- If the writeback finds the counter at 0 while an issue to r is also accepted, the result is 1 and `wb_err` is set.

`wb_err` is cleared only by reset.

## Timing
Reset (`rst_n` low, asynchronous, effective immediately and held while low):
- All `regs` = 0, all `pend` = 0, `wb_err` = 0.
- Resulting outputs: `rs1_out` = `rs2_out` = 0 (absent a bypass), `rs1_busy` = `rs2_busy` = 0, `issue_ready` = 1.
- Deassertion is synchronous to `clk` at the integration level. The block needs no internal synchronizer.
- A reset asserted mid-operation discards all pending counts and in-flight data. Writebacks arriving after reset for pre-reset issues set `wb_err`.

Latency:
- Read, bypass, busy and ready are zero-latency combinational.
- A write is visible from the array the cycle after the edge, and through the bypass in the same cycle.
- An issue makes the register busy starting the next cycle.

Edge cases:
- Issue and same-cycle read of the same register: busy reflects the pre-edge count.
- `rs1_addr`==`rs2_addr` is legal; both ports return identical values and busy.
- Counter saturation: at 3, `issue_ready`=0 for that rd. Simultaneous accepted issue and writeback never happens at 3, because ready is low.

## Test plan
- Reset then read x0..x31 -> all outputs 0, busy 0, `issue_ready` 1, `wb_err` 0.
- Issue rd=5; next cycle read rs1=5 -> `rs1_busy`=1. Writeback rd=5, data 0xDEADBEEF_00000001 -> same cycle `rs1_out` equals the data with `rs1_busy`=0; next cycle array holds the value.
- Three accepted issues to rd=7 -> `issue_ready`=0 for rd=7 and 1 for rd=8. One writeback -> ready returns to 1; rs busy stays 1 until the third writeback.
- Issue and writeback to rd=9 in the same cycle starting from pend=1 -> pend remains 1 and busy stays 1.
- Writeback to rd=0 with data 0xFFFF.. and issue rd=0 -> x0 reads 0, busy 0, `wb_err` 0. Writeback to rd=3 with pend=0 -> `wb_err`=1 and stays set; `regs[3]` is updated.
- Issue rd=4, assert `rst_n`=0 mid-cycle -> outputs return to reset values immediately. After release, writeback rd=4 -> `wb_err`=1.
